// File: rtl/bench_bist_harness.sv
// BIST harness for 32-in/32-out benchmark CUTs: a Galois LFSR drives the CUT inputs,
// a Galois MISR compacts its outputs, and the result is compared against a golden value.
module bench_bist_harness #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      CNT_W     = 16,
  parameter int unsigned      CUT_LAT   = 0,
  parameter logic [WIDTH-1:0] LFSR_POLY = 32'h80200003,
  parameter logic [WIDTH-1:0] MISR_POLY = 32'hEDB88320
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] cut_in,
  input  logic [WIDTH-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] cut_in_q, cut_in_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_pat_q, num_pat_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             start_acc;
  logic             run;
  logic             cap_tap;
  logic [WIDTH-1:0] seed_eff;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]} ^ ({WIDTH{v[0]}} & LFSR_POLY);
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]} ^ ({WIDTH{v[0]}} & MISR_POLY);
  endfunction

  always_comb begin
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    run       = (state_q == S_RUN);
    seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
  end

  // Capture-valid pipe: stage 0 is the RUN flag itself, stage CUT_LAT gates the MISR.
  if (CUT_LAT == 0) begin : g_nopipe
    assign cap_tap = run;
  end else begin : g_pipe
    logic [CUT_LAT-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = run;
      for (int unsigned i = 1; i < CUT_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      if (start_acc) begin
        pipe_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign cap_tap = pipe_q[CUT_LAT-1];
  end

  // cut_in is loaded with the first pattern on start so it is on the CUT during the
  // first RUN cycle; the LFSR therefore always runs one pattern ahead of cut_in.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cut_in_d    = cut_in_q;
    misr_d      = misr_q;
    golden_d    = golden_q;
    cnt_d       = cnt_q;
    num_pat_d   = num_pat_q;
    flush_cnt_d = flush_cnt_q;

    if (cap_tap) begin
      misr_d = misr_step(misr_q) ^ cut_out;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cut_in_d    = seed_eff;
          lfsr_d      = lfsr_step(seed_eff);
          cnt_d       = '0;
          misr_d      = '0;
          flush_cnt_d = '0;
          num_pat_d   = num_pat;
          golden_d    = golden;
          state_d     = (num_pat == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == num_pat_q - CNT_W'(1)) begin
          flush_cnt_d = '0;
          state_d     = (CUT_LAT > 0) ? S_FLUSH : S_DONE;
        end else begin
          cut_in_d = lfsr_q;
          lfsr_d   = lfsr_step(lfsr_q);
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'(CUT_LAT - 1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      cut_in_q    <= '0;
      misr_q      <= '0;
      golden_q    <= '0;
      cnt_q       <= '0;
      num_pat_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cut_in_q    <= cut_in_d;
      misr_q      <= misr_d;
      golden_q    <= golden_d;
      cnt_q       <= cnt_d;
      num_pat_q   <= num_pat_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    cut_in    = cut_in_q;
    busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    done      = (state_q == S_DONE);
    signature = misr_q;
    pass      = (state_q == S_DONE) && (misr_q == golden_q);
  end

endmodule

// File: tb/tb_bench_bist_harness.sv
// Bench for bench_bist_harness: two instances (CUT_LAT=0 with combinational loopback,
// CUT_LAT=2 with a 2-stage delayed loopback) share controls and are checked against a model.
module tb_bench_bist_harness;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] MISR_POLY = 32'hEDB88320;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] seed, golden;
  logic [15:0] num_pat;
  int          mode;
  logic [31:0] flip0;

  logic [31:0] cut_in0, cut_out0, sig0;
  logic [31:0] cut_in2, cut_out2, sig2;
  logic        busy0, done0, pass0, busy2, done2, pass2;
  logic [31:0] d1, d2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] cut_f(input logic [31:0] x, input int m);
    if (m == 0) return x;
    return {x[15:0], x[31:16]} ^ (x * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_sig(input logic [31:0] s, input int n, input int m);
    logic [31:0] p, acc;
    p   = (s == 0) ? 32'h1 : s;
    acc = 32'h0;
    for (int i = 0; i < n; i++) begin
      acc = (acc >> 1) ^ (acc[0] ? MISR_POLY : 32'h0) ^ cut_f(p, m);
      p   = lfsr_next(p);
    end
    return acc;
  endfunction

  always_comb cut_out0 = cut_f(cut_in0, mode) ^ flip0;

  always_ff @(posedge clk) begin
    d1 <= cut_f(cut_in2, mode);
    d2 <= d1;
  end
  assign cut_out2 = d2;

  bench_bist_harness #(.WIDTH(32), .CNT_W(16), .CUT_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_pat(num_pat),
    .golden(golden), .cut_in(cut_in0), .cut_out(cut_out0), .busy(busy0),
    .done(done0), .signature(sig0), .pass(pass0)
  );

  bench_bist_harness #(.WIDTH(32), .CNT_W(16), .CUT_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_pat(num_pat),
    .golden(golden), .cut_in(cut_in2), .cut_out(cut_out2), .busy(busy2),
    .done(done2), .signature(sig2), .pass(pass2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cut_in0, sig0, busy0, done0, pass0} !== '0) begin
      n_fail++;
      $display("FAIL reset_lat0: got cut_in=%h sig=%h busy=%b done=%b pass=%b want all 0",
               cut_in0, sig0, busy0, done0, pass0);
    end
    n_checks++;
    if ({cut_in2, sig2, busy2, done2, pass2} !== '0) begin
      n_fail++;
      $display("FAIL reset_lat2: got cut_in=%h sig=%h busy=%b done=%b pass=%b want all 0",
               cut_in2, sig2, busy2, done2, pass2);
    end
    rst_n = 1'b1;
  endtask

  // One complete run on both instances with cycle-by-cycle timing and pattern checks.
  task automatic run_check(input string name, input logic [31:0] s, input int n, input int m,
                           input logic [31:0] gold, input bit repulse, input int flip_cyc);
    logic [31:0] exp_sig, p, last_p;
    int          e0, e2;
    bit          ep0, ep2;
    exp_sig = model_sig(s, n, m);
    ep2     = (gold == exp_sig);
    ep0     = ep2 && (flip_cyc == 0);
    e0      = n + 1;
    e2      = (n == 0) ? 1 : n + 3;
    p       = (s == 0) ? 32'h1 : s;
    last_p  = p;
    @(negedge clk);
    seed = s; num_pat = 16'(n); golden = gold; mode = m; flip0 = '0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= e2 + 1; cyc++) begin
      n_checks++;
      if (busy0 !== (cyc <= n) || done0 !== (cyc >= e0)) begin
        n_fail++;
        $display("FAIL %s_ctl0 cyc%0d: got busy=%b done=%b want busy=%b done=%b",
                 name, cyc, busy0, done0, (cyc <= n), (cyc >= e0));
      end
      n_checks++;
      if (busy2 !== (n > 0 && cyc <= n + 2) || done2 !== (cyc >= e2)) begin
        n_fail++;
        $display("FAIL %s_ctl2 cyc%0d: got busy=%b done=%b want busy=%b done=%b",
                 name, cyc, busy2, done2, (n > 0 && cyc <= n + 2), (cyc >= e2));
      end
      if (cyc < e0) begin
        n_checks++;
        if (pass0 !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_pass_early cyc%0d: got %b want 0", name, cyc, pass0);
        end
      end
      if (cyc <= n) begin
        n_checks++;
        if (cut_in0 !== p || cut_in2 !== p) begin
          n_fail++;
          $display("FAIL %s_pattern cyc%0d: got %h/%h want %h", name, cyc, cut_in0, cut_in2, p);
        end
        last_p = p;
        p      = lfsr_next(p);
      end
      start = (repulse && cyc == 3);
      if (start) begin
        seed    = ~s;
        num_pat = 16'd7;
      end
      flip0 = (cyc == flip_cyc) ? 32'h0000_0100 : 32'h0;
      if (cyc <= e2) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    flip0 = '0;
    n_checks++;
    if (sig2 !== exp_sig || pass2 !== ep2) begin
      n_fail++;
      $display("FAIL %s_sig2: got sig=%h pass=%b want sig=%h pass=%b", name, sig2, pass2, exp_sig, ep2);
    end
    n_checks++;
    if ((flip_cyc == 0 && sig0 !== exp_sig) || (flip_cyc != 0 && sig0 === exp_sig) || pass0 !== ep0) begin
      n_fail++;
      $display("FAIL %s_sig0: got sig=%h pass=%b want sig%s%h pass=%b",
               name, sig0, pass0, (flip_cyc == 0) ? "=" : "!=", exp_sig, ep0);
    end
    if (n > 0) begin
      n_checks++;
      if (cut_in0 !== last_p) begin
        n_fail++;
        $display("FAIL %s_hold_cut_in: got %h want %h", name, cut_in0, last_p);
      end
    end
  endtask

  task automatic test_basic();
    run_check("one", 32'h1, 1, 0, 32'h1, 1'b0, 0);
    n_checks++;
    if (sig0 !== 32'h00000001) begin
      n_fail++;
      $display("FAIL one_const: got %h want 00000001", sig0);
    end
    run_check("two", 32'h1, 2, 0, 32'h6D988323, 1'b0, 0);
    n_checks++;
    if (sig0 !== 32'h6D988323 || sig2 !== 32'h6D988323 || pass0 !== 1'b1) begin
      n_fail++;
      $display("FAIL two_const: got %h/%h pass=%b want 6d988323 pass=1", sig0, sig2, pass0);
    end
  endtask

  task automatic test_edge_cases();
    run_check("seed0", 32'h0, 3, 0, model_sig(32'h1, 3, 0), 1'b0, 0);
    run_check("zero_pass", 32'h1234, 0, 1, 32'h0, 1'b0, 0);
    run_check("zero_fail", 32'h1234, 0, 1, 32'h5, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] s, g;
      int          n, m;
      s = $urandom;
      n = $urandom_range(1, 40);
      m = i % 2;
      g = model_sig(s, n, m);
      if ($urandom_range(0, 1) == 1) g = g ^ (32'h1 << $urandom_range(0, 31));
      run_check("rand", s, n, m, g, 1'b0, 0);
    end
  endtask

  task automatic test_restart_ignored();
    logic [31:0] s;
    s = $urandom;
    run_check("repulse", s, 20, 1, model_sig(s, 20, 1), 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1, s2, g1, g2;
    s1 = $urandom; s2 = $urandom;
    g1 = model_sig(s1, 3, 1);
    g2 = model_sig(s2, 5, 1);
    @(negedge clk);
    seed = s1; num_pat = 16'd3; golden = g1; mode = 1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (done0 !== 1'b1 || sig0 !== g1) begin
      n_fail++;
      $display("FAIL b2b_first_done: got done=%b sig=%h want done=1 sig=%h", done0, sig0, g1);
    end
    seed = s2; num_pat = 16'd5; golden = g2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: got done=%b busy=%b want done=0 busy=1", done0, busy0);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (done0 !== 1'b1 || sig0 !== g2 || pass0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b sig=%h pass=%b want done=1 sig=%h pass=1", done0, sig0, pass0, g2);
    end
    n_checks++;
    if (done2 !== 1'b1 || sig2 !== g1 || pass2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_flush_ignore: got done=%b sig=%h pass=%b want done=1 sig=%h pass=1", done2, sig2, pass2, g1);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    s = $urandom;
    @(negedge clk);
    seed = s; num_pat = 16'd10; golden = 32'h0; mode = 1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cut_in0, sig0, busy0, done0, pass0, cut_in2, sig2, busy2, done2, pass2} !== '0) begin
      n_fail++;
      $display("FAIL abort: got %h %h %b%b%b / %h %h %b%b%b want all 0",
               cut_in0, sig0, busy0, done0, pass0, cut_in2, sig2, busy2, done2, pass2);
    end
    rst_n = 1'b1;
    run_check("after_abort", s, 10, 1, model_sig(s, 10, 1), 1'b0, 0);
  endtask

  task automatic test_long();
    logic [31:0] s;
    s = $urandom;
    run_check("long", s, 1000, 1, model_sig(s, 1000, 1), 1'b0, 0);
    run_check("long_flip", s, 1000, 1, model_sig(s, 1000, 1), 1'b0, 500);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = '0; num_pat = '0; golden = '0; mode = 0; flip0 = '0;
    test_reset();
    test_basic();
    test_edge_cases();
    test_random();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bench_bist_harness.md
# bench_bist_harness

Self-test harness for the team's 32-in/32-out generated benchmark circuits (CUT). It is the driving and observing end of the CUT port interface. A Galois LFSR generates stimulus patterns on the CUT inputs. A MISR compacts the CUT outputs into a 32-bit signature, which is then compared against a golden value. Control is a start/done handshake, so a CPU or testbench can sweep many benchmark instances without vector files.

## Interface
- `WIDTH`, 32: CUT input/output width; all datapath registers are this width.
- `CNT_W`, 16: width of the pattern counter and `num_pat`.
- `CUT_LAT`, 0: pipeline depth of the CUT in cycles; legal range 0..3.
- `LFSR_POLY`, 32'h80200003: Galois feedback mask for the stimulus LFSR.
- `MISR_POLY`, 32'hEDB88320: Galois feedback mask for the response MISR.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to begin a run; accepted only in IDLE or DONE.
- `seed`  in  WIDTH  LFSR seed, sampled on accepted `start`.
- `num_pat`  in  CNT_W  number of patterns to apply, sampled on accepted `start`.
- `golden`  in  WIDTH  expected signature, sampled on accepted `start`.
- `cut_in`  out  WIDTH  registered stimulus driven to the CUT inputs.
- `cut_out`  in  WIDTH  CUT response.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  high in DONE; held until the next accepted `start` or reset.
- `signature`  out  WIDTH  MISR contents; final value once `done` is high.
- `pass`  out  1  `signature == golden_q`; valid only while `done` is high, otherwise 0.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE, `start`=1:
  - Load `lfsr <= (seed==0) ? 1 : seed`.
  - Clear `cnt`, `misr` and the capture pipeline.
  - Latch `num_pat_q` and `golden_q`.
  - Go to RUN; if `num_pat==0`, go directly to DONE instead.
- `start` in RUN or FLUSH is ignored, with no effect on the run in progress.
- RUN, every cycle:
  - `cut_in <= lfsr`.
  - `lfsr <= {1'b0, lfsr[W-1:1]} ^ ({W{lfsr[0]}} & LFSR_POLY)`.
  - `cnt <= cnt+1`.
  - Push a 1 into the capture-valid pipe of length `CUT_LAT+1`.
  - When `cnt == num_pat_q-1`, go to FLUSH if `CUT_LAT>0`, else to DONE.
- FLUSH: push 0s into the capture pipe; go to DONE once the pipe's last stage has consumed the final pattern (`CUT_LAT` cycles).
- Capture: in any cycle where the capture pipe output is 1, `misr <= ({1'b0, misr[W-1:1]} ^ ({W{misr[0]}} & MISR_POLY)) ^ cut_out`.
  - For `CUT_LAT=0` this samples `cut_out` in the same cycle `cut_in` shows the pattern.
- DONE: all registers hold; `cut_in` keeps the last applied pattern.
- `cnt` arithmetic is unsigned modulo 2^CNT_W. `num_pat=2^CNT_W-1` is the maximum run; there is no wrap inside a run.
- Reset values (`rst_n=0` sampled):
  - state=IDLE.
  - `cut_in`, `lfsr`, `misr`, `cnt` = 0.
  - `busy`, `done`, `pass` = 0.
- Reset mid-run aborts immediately to those values; the next `start` begins a fresh run.

## Timing
- `start` sampled at edge 0 gives RUN on cycles 1..`num_pat`, with `cut_in` showing pattern k on cycle 1+k.
- FLUSH occupies cycles `num_pat+1 .. num_pat+CUT_LAT`.
- `done` and final `signature` become visible on cycle `1+num_pat+CUT_LAT`.
- With `num_pat=0`, `done` is visible on cycle 1 with `signature=0`.
- `busy` and `done` are never high together. `done` drops on the cycle after an accepted `start`.
- Back-to-back runs: `start` on the first DONE cycle is legal; minimum restart gap is 0.
- Capture-pipe stage `CUT_LAT` aligns with the CUT pipeline. Patterns are never dropped or double-counted.

## Test plan
- `CUT_LAT=0`, `cut_out` tied to `cut_in`, `seed=1`, `num_pat=1` -> `done` at cycle 2, `signature=32'h00000001`.
- Same setup, `num_pat=2` -> `cut_in` shows 1 then 32'h80200003, `signature=32'h6D988323`, `done` at cycle 3; with `golden=32'h6D988323`, `pass=1`.
- `seed=0` -> first pattern is 1; `num_pat=0` -> `done` on cycle 1, `signature=0`, `pass=(golden==0)`.
- `CUT_LAT=2` with a 2-stage delayed loopback, `seed=1`, `num_pat=2` -> `signature=32'h6D988323`, `done` at cycle 5, `busy` high on cycles 1-4.
- `start` re-pulsed mid-RUN -> ignored, same signature. Then `rst_n=0` on cycle 3 of a 10-pattern run -> all outputs 0 next cycle; a new run then reproduces the golden signature.
- Loopback through a real benchmark CUT, 1000 patterns, compared against the software LFSR/MISR model -> `signature` matches and `pass=1`; flipping one `cut_out` bit for one cycle -> `pass=0`.
